// File: rtl/micro_tile_scheduler.sv
// micro_tile_scheduler: picks the active micro tile and sequences glitch-free clock gating and reset on every switch
//   clk, rst              : clock, async active-high reset
//   mode                  : 0 manual (host requests), 1 auto (round-robin slices)
//   tile_mask             : tiles allowed to run
//   slice_len             : auto run length in cycles, 0 disables auto switching
//   req_valid/req_sel     : manual switch request, accepted when req_ready is high
//   req_ready, req_err    : request handshake and one-cycle error pulse for masked targets
//   sel                   : tile index driving the output mux
//   tile_clk_en/tile_rst_n: per-tile clock enable and active-low reset
//   switching             : high while gapping or holding the new tile in reset
module micro_tile_scheduler #(
    parameter int SLICE_W  = 16,
    parameter int GAP_CYC  = 2,
    parameter int RST_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [3:0]         tile_mask,
    input  logic [SLICE_W-1:0] slice_len,
    input  logic               req_valid,
    input  logic [1:0]         req_sel,
    output logic               req_ready,
    output logic               req_err,
    output logic [1:0]         sel,
    output logic [3:0]         tile_clk_en,
    output logic [3:0]         tile_rst_n,
    output logic               switching
);
    typedef enum logic [1:0] {IDLE, GAP, RESET, RUN} state_t;
    state_t             state_q;
    logic [15:0]        ph_q;
    logic [SLICE_W-1:0] slc_q;
    logic [1:0]         sel_q;
    logic [3:0]         clk_en_q, rst_n_q;
    logic               switching_q, req_err_q;
    logic               acc_ok, acc_bad, expire, go_gap, go_idle, reload;
    logic [1:0]         nx, gap_sel;

    // First enabled index strictly after s (wrapping); s itself if no other tile is enabled.
    function automatic logic [1:0] next_en(input logic [3:0] m, input logic [1:0] s);
        logic [1:0] r;
        r = s;
        for (int k = 3; k >= 1; k--) if (m[s + 2'(k)]) r = s + 2'(k);
        return r;
    endfunction

    function automatic logic [1:0] low_en(input logic [3:0] m);
        logic [1:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--) if (m[i]) r = 2'(i);
        return r;
    endfunction

    assign req_ready   = ~mode & (state_q == IDLE | state_q == RUN);
    assign acc_ok      = req_valid & req_ready & tile_mask[req_sel];
    assign acc_bad     = req_valid & req_ready & ~tile_mask[req_sel];
    assign expire      = mode & (slice_len != '0) & (slc_q == slice_len - SLICE_W'(1));
    assign nx          = next_en(tile_mask, sel_q);
    assign req_err     = req_err_q;
    assign sel         = sel_q;
    assign tile_clk_en = clk_en_q;
    assign tile_rst_n  = rst_n_q;
    assign switching   = switching_q;

    // Switch decision for IDLE/RUN; priority in RUN is mask drop, then request, then slice expiry.
    always_comb begin
        go_gap  = 1'b0;
        go_idle = 1'b0;
        reload  = 1'b0;
        gap_sel = req_sel;
        if (state_q == IDLE) begin
            go_gap  = acc_ok | (mode & |tile_mask);
            gap_sel = acc_ok ? req_sel : low_en(tile_mask);
        end else if (state_q == RUN) begin
            if (!tile_mask[sel_q]) begin
                go_gap  = mode & |tile_mask;
                go_idle = ~(mode & |tile_mask);
                gap_sel = nx;
            end else if (acc_ok) begin
                go_gap = 1'b1;
            end else if (expire) begin
                go_gap  = nx != sel_q;
                reload  = nx == sel_q;
                gap_sel = nx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ph_q        <= '0;
            slc_q       <= '0;
            sel_q       <= '0;
            clk_en_q    <= '0;
            rst_n_q     <= '0;
            switching_q <= 1'b0;
            req_err_q   <= 1'b0;
        end else begin
            req_err_q <= acc_bad;
            case (state_q)
                IDLE, RUN: begin
                    if (go_gap) begin
                        // sel moves only while every clock enable is low
                        state_q     <= GAP;
                        sel_q       <= gap_sel;
                        clk_en_q    <= '0;
                        rst_n_q     <= '0;
                        switching_q <= 1'b1;
                        ph_q        <= 16'(GAP_CYC - 1);
                    end else if (go_idle) begin
                        state_q  <= IDLE;
                        clk_en_q <= '0;
                        rst_n_q  <= '0;
                        slc_q    <= '0;
                    end else if (state_q == RUN) begin
                        slc_q <= (mode && !reload) ? slc_q + SLICE_W'(1) : '0;
                    end
                end
                GAP: begin
                    if (ph_q == '0) begin
                        state_q  <= RESET;
                        clk_en_q <= 4'b0001 << sel_q;
                        ph_q     <= 16'(RST_HOLD - 1);
                    end else begin
                        ph_q <= ph_q - 16'd1;
                    end
                end
                default: begin
                    if (ph_q == '0) begin
                        state_q     <= RUN;
                        rst_n_q     <= 4'b0001 << sel_q;
                        switching_q <= 1'b0;
                        slc_q       <= '0;
                    end else begin
                        ph_q <= ph_q - 16'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_micro_tile_scheduler.sv
// tb_micro_tile_scheduler: directed checks of manual, auto, mask and reset behaviour
module tb_micro_tile_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic [3:0]  tile_mask = 4'b1111;
    logic [15:0] slice_len = '0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_sel = '0;
    logic        req_ready, req_err, switching;
    logic [1:0]  sel;
    logic [3:0]  tile_clk_en, tile_rst_n;
    int          errors = 0;
    int          checks = 0;

    micro_tile_scheduler dut (
        .clk(clk), .rst(rst), .mode(mode), .tile_mask(tile_mask), .slice_len(slice_len),
        .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready), .req_err(req_err),
        .sel(sel), .tile_clk_en(tile_clk_en), .tile_rst_n(tile_rst_n), .switching(switching)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int t);
        return 4'b0001 << t;
    endfunction

    // Advance until a tile leaves reset, counting switching samples on the way.
    task automatic wait_run(output int g);
        int n;
        g = 0;
        n = 0;
        while (tile_rst_n == 4'b0000 && n < 40) begin
            if (switching) g++;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int g, h, bad;
        @(negedge clk);
        check("rst_clk_en", 32'(tile_clk_en), 32'h0);
        check("rst_rst_n", 32'(tile_rst_n), 32'h0);
        check("rst_sel_sw_err", 32'({sel, switching, req_err}), 32'h0);
        rst = 1'b0;

        req_valid = 1'b1; req_sel = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        check("man_e0_sel", 32'(sel), 32'd2);
        check("man_e0_sw", 32'(switching), 32'd1);
        check("man_e0_clk_en", 32'(tile_clk_en), 32'h0);
        repeat (2) @(negedge clk);
        check("man_e2_clk_en", 32'(tile_clk_en), 32'h4);
        check("man_e2_rst_n", 32'(tile_rst_n), 32'h0);
        repeat (3) @(negedge clk);
        check("man_e5_rst_n", 32'(tile_rst_n), 32'h0);
        @(negedge clk);
        check("man_e6_rst_n", 32'(tile_rst_n), 32'h4);
        check("man_e6_sw", 32'(switching), 32'd0);

        req_valid = 1'b1; req_sel = 2'd1;
        @(negedge clk);
        req_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (req_ready) bad++;
            @(negedge clk);
        end
        check("ready_in_switch", 32'(bad), 32'd0);
        check("sw1_rst_n", 32'(tile_rst_n), 32'h2);
        check("sw1_ready", 32'(req_ready), 32'd1);

        tile_mask = 4'b1011; req_valid = 1'b1; req_sel = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        check("mask_req_err", 32'(req_err), 32'd1);
        check("mask_req_sel", 32'(sel), 32'd1);
        check("mask_req_en", 32'({tile_clk_en, tile_rst_n}), 32'h22);
        @(negedge clk);
        check("mask_req_err_end", 32'(req_err), 32'd0);

        req_valid = 1'b1; req_sel = 2'd1;
        @(negedge clk);
        req_valid = 1'b0;
        check("restart_sw", 32'({switching, tile_clk_en}), 32'h10);
        wait_run(g);
        check("restart_run", 32'(tile_rst_n), 32'h2);

        tile_mask = 4'b1001;
        @(negedge clk);
        check("man_drop_idle", 32'({switching, tile_clk_en, tile_rst_n}), 32'h0);
        check("man_drop_ready", 32'({req_ready, sel}), 32'h5);

        tile_mask = 4'b1011; slice_len = 16'd5; mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int t;
            t = (i == 0 || i == 3) ? 0 : (i == 1 ? 1 : 3);
            wait_run(g);
            check("rr_gap_len", 32'(g), 32'd6);
            check("rr_sel", 32'(sel), 32'(t));
            check("rr_en", 32'({tile_clk_en, tile_rst_n}), 32'({oh(t), oh(t)}));
            h = 0;
            while (tile_rst_n == oh(t) && h < 20) begin
                h++;
                @(negedge clk);
            end
            check("rr_run_len", 32'(h), 32'd5);
        end

        wait_run(g);
        check("auto_drop_pre", 32'(sel), 32'd1);
        tile_mask = 4'b1001;
        @(negedge clk);
        check("auto_drop_next", 32'({switching, sel}), 32'h7);
        wait_run(g);
        check("auto_drop_run", 32'(tile_rst_n), 32'h8);
        tile_mask = 4'b0000;
        @(negedge clk);
        check("auto_drop_idle", 32'({switching, tile_clk_en, tile_rst_n}), 32'h0);
        repeat (2) @(negedge clk);
        check("auto_idle_stay", 32'({switching, tile_clk_en, tile_rst_n}), 32'h0);

        tile_mask = 4'b0100; slice_len = 16'd3;
        wait_run(g);
        check("single_run", 32'({sel, tile_rst_n}), 32'h24);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tile_rst_n != 4'b0100 || tile_clk_en != 4'b0100 || switching) bad++;
        end
        check("single_no_drop", 32'(bad), 32'd0);

        #2 rst = 1'b1;
        #1;
        check("async_rst_en", 32'({tile_clk_en, tile_rst_n}), 32'h0);
        check("async_rst_sel_sw", 32'({sel, switching}), 32'h0);
        @(negedge clk);
        rst = 1'b0; mode = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'({req_ready, sel, tile_clk_en, tile_rst_n}), 32'h400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
